// File: rtl/dma_axi_if_param.sv
// dma_axi_if_param: parametrised AXI4 master interface for the DMA engine.
// Bridges the rd/wr streamers and the data FIFO onto AR/R/AW/W/B, with
// per-beat first/last byte strobes, drain on abort and first-error capture.
// Optional build macro: DMA_AXI_IF_PERF_EN adds R/W beat performance counters.
module dma_axi_if_param #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter int ID_W       = 4,
    parameter int MAX_RD_OUT = 4,
    parameter int MAX_WR_OUT = 4,
    parameter int DMA_ID     = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_rd_req_valid,
    output logic                o_rd_req_ready,
    input  logic [ADDR_W-1:0]   i_rd_req_addr,
    input  logic [7:0]          i_rd_req_len,
    input  logic [2:0]          i_rd_req_size,
    input  logic [DATA_W/8-1:0] i_rd_req_first_strb,
    input  logic [DATA_W/8-1:0] i_rd_req_last_strb,
    input  logic                i_wr_req_valid,
    output logic                o_wr_req_ready,
    input  logic [ADDR_W-1:0]   i_wr_req_addr,
    input  logic [7:0]          i_wr_req_len,
    input  logic [2:0]          i_wr_req_size,
    input  logic [DATA_W/8-1:0] i_wr_req_first_strb,
    input  logic [DATA_W/8-1:0] i_wr_req_last_strb,
    output logic                o_rdat_valid,
    output logic [DATA_W-1:0]   o_rdat_data,
    input  logic                i_rdat_ready,
    input  logic                i_wdat_valid,
    input  logic [DATA_W-1:0]   i_wdat_data,
    output logic                o_wdat_ready,
    output logic                o_m_ar_valid,
    input  logic                i_m_ar_ready,
    output logic [ADDR_W-1:0]   o_m_ar_addr,
    output logic [7:0]          o_m_ar_len,
    output logic [2:0]          o_m_ar_size,
    output logic [1:0]          o_m_ar_burst,
    output logic [ID_W-1:0]     o_m_ar_id,
    output logic [2:0]          o_m_ar_prot,
    input  logic                i_m_r_valid,
    output logic                o_m_r_ready,
    input  logic [DATA_W-1:0]   i_m_r_data,
    input  logic [1:0]          i_m_r_resp,
    input  logic                i_m_r_last,
    output logic                o_m_aw_valid,
    input  logic                i_m_aw_ready,
    output logic [ADDR_W-1:0]   o_m_aw_addr,
    output logic [7:0]          o_m_aw_len,
    output logic [2:0]          o_m_aw_size,
    output logic [1:0]          o_m_aw_burst,
    output logic [ID_W-1:0]     o_m_aw_id,
    output logic [2:0]          o_m_aw_prot,
    output logic                o_m_w_valid,
    input  logic                i_m_w_ready,
    output logic [DATA_W-1:0]   o_m_w_data,
    output logic [DATA_W/8-1:0] o_m_w_strb,
    output logic                o_m_w_last,
    input  logic                i_m_b_valid,
    output logic                o_m_b_ready,
    input  logic [1:0]          i_m_b_resp,
    input  logic                i_dma_active,
    input  logic                i_dma_abort,
    input  logic                i_clear_err,
    output logic                o_pend_txn,
    output logic                o_err_valid,
    output logic                o_err_src,
    output logic [ADDR_W-1:0]   o_err_addr
`ifdef DMA_AXI_IF_PERF_EN
    ,
    output logic [31:0]         o_perf_rd_beats,
    output logic [31:0]         o_perf_wr_beats
`endif
);
    localparam int STRB_W = DATA_W / 8;
    localparam int RCW    = $clog2(MAX_RD_OUT + 1);
    localparam int WCW    = $clog2(MAX_WR_OUT + 1);
    localparam int RPW    = (MAX_RD_OUT > 1) ? $clog2(MAX_RD_OUT) : 1;
    localparam int WPW    = (MAX_WR_OUT > 1) ? $clog2(MAX_WR_OUT) : 1;

    // Byte enables for one beat: first/last strobes at the burst edges, both for single-beat bursts
    function automatic logic [STRB_W-1:0] beat_strb(input logic [7:0] beat, input logic [7:0] len,
                                                    input logic [STRB_W-1:0] fs, input logic [STRB_W-1:0] ls);
        logic [STRB_W-1:0] s;
        s = '1;
        if (len == 8'd0)       s = fs & ls;
        else if (beat == 8'd0) s = fs;
        else if (beat == len)  s = ls;
        return s;
    endfunction

    // Zero every byte whose strobe bit is clear
    function automatic logic [DATA_W-1:0] mask_data(input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < STRB_W; i++) m[8*i +: 8] = s[i] ? d[8*i +: 8] : 8'h00;
        return m;
    endfunction

    logic              r_ar_valid, r_aw_valid;
    logic [ADDR_W-1:0] r_ar_addr, r_aw_addr;
    logic [7:0]        r_ar_len, r_aw_len;
    logic [2:0]        r_ar_size, r_aw_size;
    logic [RCW-1:0]    r_rd_out;
    logic [WCW-1:0]    r_wr_out, r_wctx_cnt;
    logic [ADDR_W-1:0] r_rctx_addr [MAX_RD_OUT];
    logic [7:0]        r_rctx_len  [MAX_RD_OUT];
    logic [STRB_W-1:0] r_rctx_fs   [MAX_RD_OUT];
    logic [STRB_W-1:0] r_rctx_ls   [MAX_RD_OUT];
    logic [RPW-1:0]    r_rctx_wp, r_rctx_rp;
    logic [7:0]        r_wctx_len  [MAX_WR_OUT];
    logic [STRB_W-1:0] r_wctx_fs   [MAX_WR_OUT];
    logic [STRB_W-1:0] r_wctx_ls   [MAX_WR_OUT];
    logic [WPW-1:0]    r_wctx_wp, r_wctx_rp;
    logic [ADDR_W-1:0] r_bctx_addr [MAX_WR_OUT];
    logic [WPW-1:0]    r_bctx_wp, r_bctx_rp;
    logic [7:0]        r_rd_beat, r_wr_beat;
    logic              r_err_valid, r_err_src;
    logic [ADDR_W-1:0] r_err_addr;

    logic              w_rd_accept, w_wr_accept, w_r_hs, w_r_pop, w_w_hs, w_w_pop, w_b_hs;
    logic              w_rd_err, w_wr_err, w_wctx_ne;
    logic [STRB_W-1:0] w_r_strb, w_w_strb;
    logic [7:0]        w_w_len;
    logic              w_unused;

    assign w_rd_accept = rst_n && i_dma_active && i_rd_req_valid && !r_ar_valid && (r_rd_out < RCW'(MAX_RD_OUT));
    assign w_wr_accept = rst_n && i_dma_active && i_wr_req_valid && !r_aw_valid && (r_wr_out < WCW'(MAX_WR_OUT));
    assign o_rd_req_ready = w_rd_accept;
    assign o_wr_req_ready = w_wr_accept;

    assign o_m_ar_valid = r_ar_valid;
    assign o_m_ar_addr  = r_ar_addr;
    assign o_m_ar_len   = r_ar_len;
    assign o_m_ar_size  = r_ar_size;
    assign o_m_ar_burst = 2'b01;
    assign o_m_ar_id    = ID_W'(DMA_ID);
    assign o_m_ar_prot  = 3'b010;
    assign o_m_aw_valid = r_aw_valid;
    assign o_m_aw_addr  = r_aw_addr;
    assign o_m_aw_len   = r_aw_len;
    assign o_m_aw_size  = r_aw_size;
    assign o_m_aw_burst = 2'b01;
    assign o_m_aw_id    = ID_W'(DMA_ID);
    assign o_m_aw_prot  = 3'b010;

    assign o_m_r_ready  = rst_n && (i_rdat_ready || i_dma_abort);
    assign o_rdat_valid = rst_n && i_m_r_valid && !i_dma_abort;
    assign w_r_hs       = i_m_r_valid && o_m_r_ready;
    assign w_r_pop      = w_r_hs && i_m_r_last;
    assign w_r_strb     = beat_strb(r_rd_beat, r_rctx_len[r_rctx_rp], r_rctx_fs[r_rctx_rp], r_rctx_ls[r_rctx_rp]);
    assign o_rdat_data  = mask_data(i_m_r_data, w_r_strb);

    assign w_wctx_ne    = (r_wctx_cnt != '0);
    assign w_w_len      = r_wctx_len[r_wctx_rp];
    assign w_w_strb     = beat_strb(r_wr_beat, w_w_len, r_wctx_fs[r_wctx_rp], r_wctx_ls[r_wctx_rp]);
    assign o_m_w_valid  = w_wctx_ne && (i_wdat_valid || i_dma_abort);
    assign o_m_w_data   = i_dma_abort ? '0 : i_wdat_data;
    assign o_m_w_strb   = i_dma_abort ? '0 : w_w_strb;
    assign o_m_w_last   = (r_wr_beat == w_w_len);
    assign o_wdat_ready = o_m_w_valid && i_m_w_ready && !i_dma_abort;
    assign w_w_hs       = o_m_w_valid && i_m_w_ready;
    assign w_w_pop      = w_w_hs && o_m_w_last;

    assign o_m_b_ready  = rst_n;
    assign w_b_hs       = i_m_b_valid && o_m_b_ready;

    assign w_rd_err = w_r_hs && i_m_r_resp[1];
    assign w_wr_err = w_b_hs && i_m_b_resp[1];
    assign w_unused = ^{i_m_r_resp[0], i_m_b_resp[0]};

    assign o_pend_txn  = (|r_rd_out) || (|r_wr_out) || r_ar_valid || r_aw_valid;
    assign o_err_valid = r_err_valid;
    assign o_err_src   = r_err_src;
    assign o_err_addr  = r_err_addr;

    // Read side: AR output register, outstanding count and read context FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ar_valid <= 1'b0;
            r_ar_addr  <= '0;
            r_ar_len   <= '0;
            r_ar_size  <= '0;
            r_rd_out   <= '0;
            r_rctx_wp  <= '0;
            r_rctx_rp  <= '0;
            for (int i = 0; i < MAX_RD_OUT; i++) begin
                r_rctx_addr[i] <= '0;
                r_rctx_len[i]  <= '0;
                r_rctx_fs[i]   <= '0;
                r_rctx_ls[i]   <= '0;
            end
        end else begin
            if (w_rd_accept) begin
                r_ar_valid             <= 1'b1;
                r_ar_addr              <= i_rd_req_addr;
                r_ar_len               <= i_rd_req_len;
                r_ar_size              <= i_rd_req_size;
                r_rctx_addr[r_rctx_wp] <= i_rd_req_addr;
                r_rctx_len[r_rctx_wp]  <= i_rd_req_len;
                r_rctx_fs[r_rctx_wp]   <= i_rd_req_first_strb;
                r_rctx_ls[r_rctx_wp]   <= i_rd_req_last_strb;
                r_rctx_wp <= (r_rctx_wp == RPW'(MAX_RD_OUT - 1)) ? '0 : r_rctx_wp + 1'b1;
            end else if (i_m_ar_ready) begin
                r_ar_valid <= 1'b0;
            end
            if (w_r_pop) r_rctx_rp <= (r_rctx_rp == RPW'(MAX_RD_OUT - 1)) ? '0 : r_rctx_rp + 1'b1;
            case ({w_rd_accept, w_r_pop})
                2'b10:   r_rd_out <= r_rd_out + 1'b1;
                2'b01:   r_rd_out <= r_rd_out - 1'b1;
                default: r_rd_out <= r_rd_out;
            endcase
        end
    end

    // Write side: AW output register, outstanding count, W and B context FIFOs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aw_valid <= 1'b0;
            r_aw_addr  <= '0;
            r_aw_len   <= '0;
            r_aw_size  <= '0;
            r_wr_out   <= '0;
            r_wctx_cnt <= '0;
            r_wctx_wp  <= '0;
            r_wctx_rp  <= '0;
            r_bctx_wp  <= '0;
            r_bctx_rp  <= '0;
            for (int i = 0; i < MAX_WR_OUT; i++) begin
                r_wctx_len[i]  <= '0;
                r_wctx_fs[i]   <= '0;
                r_wctx_ls[i]   <= '0;
                r_bctx_addr[i] <= '0;
            end
        end else begin
            if (w_wr_accept) begin
                r_aw_valid             <= 1'b1;
                r_aw_addr              <= i_wr_req_addr;
                r_aw_len               <= i_wr_req_len;
                r_aw_size              <= i_wr_req_size;
                r_wctx_len[r_wctx_wp]  <= i_wr_req_len;
                r_wctx_fs[r_wctx_wp]   <= i_wr_req_first_strb;
                r_wctx_ls[r_wctx_wp]   <= i_wr_req_last_strb;
                r_bctx_addr[r_bctx_wp] <= i_wr_req_addr;
                r_wctx_wp <= (r_wctx_wp == WPW'(MAX_WR_OUT - 1)) ? '0 : r_wctx_wp + 1'b1;
                r_bctx_wp <= (r_bctx_wp == WPW'(MAX_WR_OUT - 1)) ? '0 : r_bctx_wp + 1'b1;
            end else if (i_m_aw_ready) begin
                r_aw_valid <= 1'b0;
            end
            if (w_w_pop) r_wctx_rp <= (r_wctx_rp == WPW'(MAX_WR_OUT - 1)) ? '0 : r_wctx_rp + 1'b1;
            if (w_b_hs)  r_bctx_rp <= (r_bctx_rp == WPW'(MAX_WR_OUT - 1)) ? '0 : r_bctx_rp + 1'b1;
            case ({w_wr_accept, w_w_pop})
                2'b10:   r_wctx_cnt <= r_wctx_cnt + 1'b1;
                2'b01:   r_wctx_cnt <= r_wctx_cnt - 1'b1;
                default: r_wctx_cnt <= r_wctx_cnt;
            endcase
            case ({w_wr_accept, w_b_hs})
                2'b10:   r_wr_out <= r_wr_out + 1'b1;
                2'b01:   r_wr_out <= r_wr_out - 1'b1;
                default: r_wr_out <= r_wr_out;
            endcase
        end
    end

    // Beat counters locate each beat within its burst; they restart after the last beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_beat <= '0;
            r_wr_beat <= '0;
        end else begin
            if (w_r_pop)     r_rd_beat <= '0;
            else if (w_r_hs) r_rd_beat <= r_rd_beat + 1'b1;
            if (w_w_pop)     r_wr_beat <= '0;
            else if (w_w_hs) r_wr_beat <= r_wr_beat + 1'b1;
        end
    end

    // First-error record: locks on capture, read beats write on ties, clear beats new errors
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_valid <= 1'b0;
            r_err_src   <= 1'b0;
            r_err_addr  <= '0;
        end else if (i_clear_err) begin
            r_err_valid <= 1'b0;
            r_err_src   <= 1'b0;
            r_err_addr  <= '0;
        end else if (!r_err_valid) begin
            if (w_rd_err) begin
                r_err_valid <= 1'b1;
                r_err_src   <= 1'b0;
                r_err_addr  <= r_rctx_addr[r_rctx_rp];
            end else if (w_wr_err) begin
                r_err_valid <= 1'b1;
                r_err_src   <= 1'b1;
                r_err_addr  <= r_bctx_addr[r_bctx_rp];
            end
        end
    end

`ifdef DMA_AXI_IF_PERF_EN
    logic [31:0] r_perf_rd, r_perf_wr;
    assign o_perf_rd_beats = r_perf_rd;
    assign o_perf_wr_beats = r_perf_wr;

    // Saturating R and W beat counters, cleared together with the error record
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_rd <= '0;
            r_perf_wr <= '0;
        end else if (i_clear_err) begin
            r_perf_rd <= '0;
            r_perf_wr <= '0;
        end else begin
            if (w_r_hs && (r_perf_rd != '1)) r_perf_rd <= r_perf_rd + 1'b1;
            if (w_w_hs && (r_perf_wr != '1)) r_perf_wr <= r_perf_wr + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_dma_axi_if_param.sv
// tb_dma_axi_if_param: directed self-checking bench for dma_axi_if_param
// with default parameters (ADDR_W=32, DATA_W=64, MAX_RD_OUT=MAX_WR_OUT=4).
module tb_dma_axi_if_param;
    logic        clk, rst_n;
    logic        i_rd_req_valid, o_rd_req_ready;
    logic [31:0] i_rd_req_addr;
    logic [7:0]  i_rd_req_len;
    logic [2:0]  i_rd_req_size;
    logic [7:0]  i_rd_req_first_strb, i_rd_req_last_strb;
    logic        i_wr_req_valid, o_wr_req_ready;
    logic [31:0] i_wr_req_addr;
    logic [7:0]  i_wr_req_len;
    logic [2:0]  i_wr_req_size;
    logic [7:0]  i_wr_req_first_strb, i_wr_req_last_strb;
    logic        o_rdat_valid, i_rdat_ready;
    logic [63:0] o_rdat_data;
    logic        i_wdat_valid, o_wdat_ready;
    logic [63:0] i_wdat_data;
    logic        o_m_ar_valid, i_m_ar_ready;
    logic [31:0] o_m_ar_addr;
    logic [7:0]  o_m_ar_len;
    logic [2:0]  o_m_ar_size, o_m_ar_prot;
    logic [1:0]  o_m_ar_burst;
    logic [3:0]  o_m_ar_id;
    logic        i_m_r_valid, o_m_r_ready, i_m_r_last;
    logic [63:0] i_m_r_data;
    logic [1:0]  i_m_r_resp;
    logic        o_m_aw_valid, i_m_aw_ready;
    logic [31:0] o_m_aw_addr;
    logic [7:0]  o_m_aw_len;
    logic [2:0]  o_m_aw_size, o_m_aw_prot;
    logic [1:0]  o_m_aw_burst;
    logic [3:0]  o_m_aw_id;
    logic        o_m_w_valid, i_m_w_ready, o_m_w_last;
    logic [63:0] o_m_w_data;
    logic [7:0]  o_m_w_strb;
    logic        i_m_b_valid, o_m_b_ready;
    logic [1:0]  i_m_b_resp;
    logic        i_dma_active, i_dma_abort, i_clear_err;
    logic        o_pend_txn, o_err_valid, o_err_src;
    logic [31:0] o_err_addr;
`ifdef DMA_AXI_IF_PERF_EN
    logic [31:0] o_perf_rd_beats, o_perf_wr_beats;
`endif

    int nChecks = 0;
    int nFails  = 0;

    dma_axi_if_param dut (
        .clk(clk), .rst_n(rst_n),
        .i_rd_req_valid(i_rd_req_valid), .o_rd_req_ready(o_rd_req_ready), .i_rd_req_addr(i_rd_req_addr),
        .i_rd_req_len(i_rd_req_len), .i_rd_req_size(i_rd_req_size),
        .i_rd_req_first_strb(i_rd_req_first_strb), .i_rd_req_last_strb(i_rd_req_last_strb),
        .i_wr_req_valid(i_wr_req_valid), .o_wr_req_ready(o_wr_req_ready), .i_wr_req_addr(i_wr_req_addr),
        .i_wr_req_len(i_wr_req_len), .i_wr_req_size(i_wr_req_size),
        .i_wr_req_first_strb(i_wr_req_first_strb), .i_wr_req_last_strb(i_wr_req_last_strb),
        .o_rdat_valid(o_rdat_valid), .o_rdat_data(o_rdat_data), .i_rdat_ready(i_rdat_ready),
        .i_wdat_valid(i_wdat_valid), .i_wdat_data(i_wdat_data), .o_wdat_ready(o_wdat_ready),
        .o_m_ar_valid(o_m_ar_valid), .i_m_ar_ready(i_m_ar_ready), .o_m_ar_addr(o_m_ar_addr),
        .o_m_ar_len(o_m_ar_len), .o_m_ar_size(o_m_ar_size), .o_m_ar_burst(o_m_ar_burst),
        .o_m_ar_id(o_m_ar_id), .o_m_ar_prot(o_m_ar_prot),
        .i_m_r_valid(i_m_r_valid), .o_m_r_ready(o_m_r_ready), .i_m_r_data(i_m_r_data),
        .i_m_r_resp(i_m_r_resp), .i_m_r_last(i_m_r_last),
        .o_m_aw_valid(o_m_aw_valid), .i_m_aw_ready(i_m_aw_ready), .o_m_aw_addr(o_m_aw_addr),
        .o_m_aw_len(o_m_aw_len), .o_m_aw_size(o_m_aw_size), .o_m_aw_burst(o_m_aw_burst),
        .o_m_aw_id(o_m_aw_id), .o_m_aw_prot(o_m_aw_prot),
        .o_m_w_valid(o_m_w_valid), .i_m_w_ready(i_m_w_ready), .o_m_w_data(o_m_w_data),
        .o_m_w_strb(o_m_w_strb), .o_m_w_last(o_m_w_last),
        .i_m_b_valid(i_m_b_valid), .o_m_b_ready(o_m_b_ready), .i_m_b_resp(i_m_b_resp),
        .i_dma_active(i_dma_active), .i_dma_abort(i_dma_abort), .i_clear_err(i_clear_err),
        .o_pend_txn(o_pend_txn), .o_err_valid(o_err_valid), .o_err_src(o_err_src), .o_err_addr(o_err_addr)
`ifdef DMA_AXI_IF_PERF_EN
        , .o_perf_rd_beats(o_perf_rd_beats), .o_perf_wr_beats(o_perf_wr_beats)
`endif
    );

    // Free-running 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive every input to its quiet value
    task automatic idleInputs;
        i_rd_req_valid = 0; i_rd_req_addr = '0; i_rd_req_len = '0; i_rd_req_size = 3'd3;
        i_rd_req_first_strb = '0; i_rd_req_last_strb = '0;
        i_wr_req_valid = 0; i_wr_req_addr = '0; i_wr_req_len = '0; i_wr_req_size = 3'd3;
        i_wr_req_first_strb = '0; i_wr_req_last_strb = '0;
        i_rdat_ready = 0; i_wdat_valid = 0; i_wdat_data = '0;
        i_m_ar_ready = 0; i_m_r_valid = 0; i_m_r_data = '0; i_m_r_resp = 2'b00; i_m_r_last = 0;
        i_m_aw_ready = 0; i_m_w_ready = 0; i_m_b_valid = 0; i_m_b_resp = 2'b00;
        i_dma_abort = 0; i_clear_err = 0;
    endtask

    // Issue one read request and complete its AR handshake; the burst stays outstanding
    task automatic doRead(input logic [31:0] addr, input logic [7:0] len, input logic [7:0] fs, input logic [7:0] ls);
        i_rd_req_valid = 1; i_rd_req_addr = addr; i_rd_req_len = len;
        i_rd_req_first_strb = fs; i_rd_req_last_strb = ls;
        tick;
        i_rd_req_valid = 0; i_m_ar_ready = 1;
        tick;
        i_m_ar_ready = 0;
    endtask

    // Issue one write request, its AW handshake and all W beats, optionally followed by B
    task automatic doWrite(input logic [31:0] addr, input logic [7:0] len, input logic [7:0] fs, input logic [7:0] ls,
                           input logic sendB, input logic [1:0] bresp, input logic clr);
        i_wr_req_valid = 1; i_wr_req_addr = addr; i_wr_req_len = len;
        i_wr_req_first_strb = fs; i_wr_req_last_strb = ls;
        tick;
        i_wr_req_valid = 0; i_m_aw_ready = 1; i_m_w_ready = 1;
        for (int i = 0; i <= int'(len); i++) begin
            i_wdat_valid = 1; i_wdat_data = 64'h1000 + 64'(i);
            tick;
            i_m_aw_ready = 0;
        end
        i_wdat_valid = 0; i_m_w_ready = 0;
        if (sendB) begin
            i_m_b_valid = 1; i_m_b_resp = bresp; i_clear_err = clr;
            tick;
            i_m_b_valid = 0; i_m_b_resp = 2'b00; i_clear_err = 0;
        end
    endtask

    task automatic test_reset;
        idleInputs;
        i_dma_active = 1; i_rd_req_valid = 1; i_m_r_valid = 1; i_rdat_ready = 1; i_wdat_valid = 1;
        rst_n = 0;
        repeat (2) tick;
        nChecks++; if (o_m_ar_valid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_ar_valid: got %b want 0", o_m_ar_valid); end
        nChecks++; if (o_m_aw_valid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_aw_valid: got %b want 0", o_m_aw_valid); end
        nChecks++; if (o_m_w_valid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_w_valid: got %b want 0", o_m_w_valid); end
        nChecks++; if (o_rdat_valid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_rdat_valid: got %b want 0", o_rdat_valid); end
        nChecks++; if (o_rd_req_ready !== 1'b0) begin nFails++; $display("[TB] FAIL reset_rd_req_ready: got %b want 0", o_rd_req_ready); end
        nChecks++; if (o_m_r_ready !== 1'b0) begin nFails++; $display("[TB] FAIL reset_r_ready: got %b want 0", o_m_r_ready); end
        nChecks++; if (o_pend_txn !== 1'b0) begin nFails++; $display("[TB] FAIL reset_pend_txn: got %b want 0", o_pend_txn); end
        nChecks++; if ({o_err_valid, o_err_src, o_err_addr} !== 34'h0) begin nFails++; $display("[TB] FAIL reset_err: got %b %b %h want 0 0 0", o_err_valid, o_err_src, o_err_addr); end
        idleInputs;
        rst_n = 1;
        tick;
    endtask

    task automatic test_read_strobes;
        logic [63:0] expR [4];
        expR = '{64'hFFFFFFFF00000000, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h00000000FFFFFFFF};
        i_rd_req_valid = 1; i_rd_req_addr = 32'h1000; i_rd_req_len = 8'd3;
        i_rd_req_first_strb = 8'hF0; i_rd_req_last_strb = 8'h0F;
        #1;
        nChecks++; if (o_rd_req_ready !== 1'b1) begin nFails++; $display("[TB] FAIL rd_accept: got %b want 1", o_rd_req_ready); end
        tick;
        i_rd_req_valid = 0; i_m_ar_ready = 1;
        #1;
        nChecks++; if (o_rd_req_ready !== 1'b0) begin nFails++; $display("[TB] FAIL rd_ready_pulse: got %b want 0", o_rd_req_ready); end
        nChecks++; if ({o_m_ar_valid, o_m_ar_addr, o_m_ar_len} !== {1'b1, 32'h1000, 8'd3}) begin nFails++; $display("[TB] FAIL ar_fields: got %b %h %h want 1 00001000 03", o_m_ar_valid, o_m_ar_addr, o_m_ar_len); end
        nChecks++; if ({o_m_ar_burst, o_m_ar_prot, o_m_ar_id, o_m_ar_size} !== {2'b01, 3'b010, 4'h0, 3'd3}) begin nFails++; $display("[TB] FAIL ar_const: got %b %b %h %h want 01 010 0 3", o_m_ar_burst, o_m_ar_prot, o_m_ar_id, o_m_ar_size); end
        tick;
        i_m_ar_ready = 0; i_rdat_ready = 1;
        for (int b = 0; b < 4; b++) begin
            i_m_r_valid = 1; i_m_r_data = '1; i_m_r_last = (b == 3);
            #1;
            nChecks++; if ({o_rdat_valid, o_rdat_data} !== {1'b1, expR[b]}) begin nFails++; $display("[TB] FAIL rd_beat%0d: got %b %h want 1 %h", b, o_rdat_valid, o_rdat_data, expR[b]); end
            tick;
        end
        i_m_r_valid = 0; i_m_r_last = 0;
        #1;
        nChecks++; if (o_pend_txn !== 1'b0) begin nFails++; $display("[TB] FAIL rd_drain_pend: got %b want 0", o_pend_txn); end
        doRead(32'h1100, 8'd0, 8'hF0, 8'h3C);
        i_m_r_valid = 1; i_m_r_data = 64'h0123456789ABCDEF; i_m_r_last = 1;
        #1;
        nChecks++; if (o_rdat_data !== 64'h0000456700000000) begin nFails++; $display("[TB] FAIL rd_len0_mask: got %h want 0000456700000000", o_rdat_data); end
        tick;
        i_m_r_valid = 0; i_m_r_last = 0; i_rdat_ready = 0;
    endtask

    task automatic test_rd_outstanding;
        int idx = 0;
        int nAcc = 0;
        int nAr = 0;
        logic found = 0;
        i_dma_active = 0; i_rd_req_valid = 1; i_rd_req_addr = 32'h5000; i_rd_req_len = 8'd0;
        #1;
        nChecks++; if (o_rd_req_ready !== 1'b0) begin nFails++; $display("[TB] FAIL inactive_block: got %b want 0", o_rd_req_ready); end
        tick;
        i_dma_active = 1; i_m_ar_ready = 1;
        for (int c = 0; c < 16; c++) begin
            i_rd_req_valid = (idx < 5); i_rd_req_addr = 32'h5000 + 32'(idx) * 32'h100;
            #1;
            if (o_rd_req_ready) begin nAcc++; idx++; end
            if (o_m_ar_valid && i_m_ar_ready) nAr++;
            tick;
        end
        nChecks++; if (nAcc !== 4) begin nFails++; $display("[TB] FAIL rd_max_accepts: got %0d want 4", nAcc); end
        nChecks++; if (nAr !== 4) begin nFails++; $display("[TB] FAIL rd_max_ar_hs: got %0d want 4", nAr); end
        i_m_r_valid = 1; i_m_r_last = 1; i_rdat_ready = 1;
        #1;
        nChecks++; if (o_rd_req_ready !== 1'b0) begin nFails++; $display("[TB] FAIL rd_fifth_held: got %b want 0", o_rd_req_ready); end
        tick;
        i_m_r_valid = 0;
        for (int k = 0; k < 4 && !found; k++) begin
            #1;
            if (o_rd_req_ready) found = 1;
            tick;
        end
        nChecks++; if (found !== 1'b1) begin nFails++; $display("[TB] FAIL rd_fifth_release: got %b want 1", found); end
        i_rd_req_valid = 0;
        tick;
        i_m_ar_ready = 0;
        i_m_r_valid = 1;
        repeat (4) tick;
        i_m_r_valid = 0; i_m_r_last = 0; i_rdat_ready = 0;
        #1;
        nChecks++; if (o_pend_txn !== 1'b0) begin nFails++; $display("[TB] FAIL rd_out_drain: got %b want 0", o_pend_txn); end
    endtask

    task automatic test_write_aw_stall;
        i_wr_req_valid = 1; i_wr_req_addr = 32'h3000; i_wr_req_len = 8'd1;
        i_wr_req_first_strb = 8'hFF; i_wr_req_last_strb = 8'h0F;
        #1;
        nChecks++; if (o_wr_req_ready !== 1'b1) begin nFails++; $display("[TB] FAIL wr_accept: got %b want 1", o_wr_req_ready); end
        tick;
        i_wr_req_valid = 0; i_m_w_ready = 1;
        for (int c = 1; c <= 10; c++) begin
            i_wdat_valid = (c <= 2); i_wdat_data = (c == 1) ? 64'hA0A0A0A0A0A0A0A0 : 64'hB1B1B1B1B1B1B1B1;
            #1;
            nChecks++; if ({o_m_aw_valid, o_m_aw_addr} !== {1'b1, 32'h3000}) begin nFails++; $display("[TB] FAIL aw_stable_c%0d: got %b %h want 1 00003000", c, o_m_aw_valid, o_m_aw_addr); end
            if (c == 1) begin
                nChecks++; if ({o_m_w_valid, o_m_w_strb, o_m_w_last, o_wdat_ready, o_m_w_data} !== {1'b1, 8'hFF, 1'b0, 1'b1, 64'hA0A0A0A0A0A0A0A0}) begin nFails++; $display("[TB] FAIL w_beat0: got %b %h %b %b %h want 1 ff 0 1 a0a0a0a0a0a0a0a0", o_m_w_valid, o_m_w_strb, o_m_w_last, o_wdat_ready, o_m_w_data); end
            end else if (c == 2) begin
                nChecks++; if ({o_m_w_valid, o_m_w_strb, o_m_w_last, o_wdat_ready, o_m_w_data} !== {1'b1, 8'h0F, 1'b1, 1'b1, 64'hB1B1B1B1B1B1B1B1}) begin nFails++; $display("[TB] FAIL w_beat1: got %b %h %b %b %h want 1 0f 1 1 b1b1b1b1b1b1b1b1", o_m_w_valid, o_m_w_strb, o_m_w_last, o_wdat_ready, o_m_w_data); end
            end else if (c == 3) begin
                nChecks++; if (o_m_w_valid !== 1'b0) begin nFails++; $display("[TB] FAIL w_done: got %b want 0", o_m_w_valid); end
            end
            tick;
        end
        i_m_w_ready = 0; i_m_aw_ready = 1;
        tick;
        i_m_aw_ready = 0; i_m_b_valid = 1; i_m_b_resp = 2'b00;
        #1;
        nChecks++; if ({o_m_aw_valid, o_m_b_ready, o_pend_txn} !== 3'b011) begin nFails++; $display("[TB] FAIL b_wait: got %b%b%b want 011", o_m_aw_valid, o_m_b_ready, o_pend_txn); end
        tick;
        i_m_b_valid = 0;
        #1;
        nChecks++; if (o_pend_txn !== 1'b0) begin nFails++; $display("[TB] FAIL wr_out_drain: got %b want 0", o_pend_txn); end
    endtask

    task automatic test_abort;
        i_dma_abort = 1;
        i_wr_req_valid = 1; i_wr_req_addr = 32'h3800; i_wr_req_len = 8'd3;
        i_wr_req_first_strb = 8'h0F; i_wr_req_last_strb = 8'hF0;
        tick;
        i_wr_req_valid = 0; i_m_aw_ready = 1; i_m_w_ready = 1; i_wdat_valid = 0;
        for (int b = 0; b < 4; b++) begin
            #1;
            nChecks++; if ({o_m_w_valid, o_m_w_strb, o_m_w_data, o_m_w_last, o_wdat_ready} !== {1'b1, 8'h00, 64'h0, (b == 3), 1'b0}) begin nFails++; $display("[TB] FAIL abort_w%0d: got %b %h %h %b %b want 1 00 0 %b 0", b, o_m_w_valid, o_m_w_strb, o_m_w_data, o_m_w_last, o_wdat_ready, (b == 3)); end
            tick;
            i_m_aw_ready = 0;
        end
        #1;
        nChecks++; if (o_m_w_valid !== 1'b0) begin nFails++; $display("[TB] FAIL abort_w_end: got %b want 0", o_m_w_valid); end
        i_m_w_ready = 0; i_m_b_valid = 1;
        tick;
        i_m_b_valid = 0;
        doRead(32'h3900, 8'd0, 8'hFF, 8'hFF);
        i_rdat_ready = 0; i_m_r_valid = 1; i_m_r_last = 1;
        #1;
        nChecks++; if ({o_rdat_valid, o_m_r_ready} !== 2'b01) begin nFails++; $display("[TB] FAIL abort_r_discard: got %b%b want 01", o_rdat_valid, o_m_r_ready); end
        tick;
        i_m_r_valid = 0; i_m_r_last = 0; i_dma_abort = 0;
        #1;
        nChecks++; if (o_pend_txn !== 1'b0) begin nFails++; $display("[TB] FAIL abort_drain: got %b want 0", o_pend_txn); end
    endtask

    task automatic test_errors;
        doRead(32'h2000, 8'd1, 8'hFF, 8'hFF);
        i_rdat_ready = 1; i_m_r_valid = 1; i_m_r_resp = 2'b10; i_m_r_last = 0;
        tick;
        i_m_r_resp = 2'b00; i_m_r_last = 1;
        #1;
        nChecks++; if ({o_err_valid, o_err_src, o_err_addr} !== {1'b1, 1'b0, 32'h2000}) begin nFails++; $display("[TB] FAIL err_rd_capture: got %b %b %h want 1 0 00002000", o_err_valid, o_err_src, o_err_addr); end
        tick;
        i_m_r_valid = 0; i_m_r_last = 0; i_rdat_ready = 0;
        doWrite(32'h4000, 8'd0, 8'hFF, 8'hFF, 1'b1, 2'b11, 1'b0);
        #1;
        nChecks++; if ({o_err_valid, o_err_src, o_err_addr} !== {1'b1, 1'b0, 32'h2000}) begin nFails++; $display("[TB] FAIL err_locked: got %b %b %h want 1 0 00002000", o_err_valid, o_err_src, o_err_addr); end
        i_clear_err = 1;
        tick;
        i_clear_err = 0;
        #1;
        nChecks++; if ({o_err_valid, o_err_src, o_err_addr} !== 34'h0) begin nFails++; $display("[TB] FAIL err_clear: got %b %b %h want 0 0 0", o_err_valid, o_err_src, o_err_addr); end
        doWrite(32'h5000, 8'd0, 8'hFF, 8'hFF, 1'b1, 2'b11, 1'b1);
        #1;
        nChecks++; if (o_err_valid !== 1'b0) begin nFails++; $display("[TB] FAIL err_clear_wins: got %b want 0", o_err_valid); end
        doWrite(32'h6000, 8'd2, 8'hFF, 8'hFF, 1'b1, 2'b10, 1'b0);
        #1;
        nChecks++; if ({o_err_valid, o_err_src, o_err_addr} !== {1'b1, 1'b1, 32'h6000}) begin nFails++; $display("[TB] FAIL err_wr_capture: got %b %b %h want 1 1 00006000", o_err_valid, o_err_src, o_err_addr); end
        i_clear_err = 1;
        tick;
        i_clear_err = 0;
        doRead(32'h7000, 8'd0, 8'hFF, 8'hFF);
        doWrite(32'h8000, 8'd0, 8'hFF, 8'hFF, 1'b0, 2'b00, 1'b0);
        i_rdat_ready = 1; i_m_r_valid = 1; i_m_r_resp = 2'b10; i_m_r_last = 1;
        i_m_b_valid = 1; i_m_b_resp = 2'b11;
        tick;
        i_m_r_valid = 0; i_m_r_resp = 2'b00; i_m_r_last = 0; i_rdat_ready = 0;
        i_m_b_valid = 0; i_m_b_resp = 2'b00;
        #1;
        nChecks++; if ({o_err_valid, o_err_src, o_err_addr} !== {1'b1, 1'b0, 32'h7000}) begin nFails++; $display("[TB] FAIL err_read_wins: got %b %b %h want 1 0 00007000", o_err_valid, o_err_src, o_err_addr); end
        nChecks++; if (o_pend_txn !== 1'b0) begin nFails++; $display("[TB] FAIL err_drain: got %b want 0", o_pend_txn); end
        i_clear_err = 1;
        tick;
        i_clear_err = 0;
    endtask

    task automatic test_async_reset;
        doRead(32'h9000, 8'd3, 8'hFF, 8'hFF);
        i_rdat_ready = 1; i_m_r_valid = 1; i_m_r_resp = 2'b10;
        tick;
        i_m_r_resp = 2'b00;
        i_wr_req_valid = 1; i_wr_req_addr = 32'hA000; i_wr_req_len = 8'd1;
        tick;
        i_wr_req_valid = 0; i_wdat_valid = 1; i_m_w_ready = 0;
        #1;
        nChecks++; if ({o_m_aw_valid, o_pend_txn, o_err_valid, o_m_w_valid} !== 4'b1111) begin nFails++; $display("[TB] FAIL prereset_state: got %b%b%b%b want 1111", o_m_aw_valid, o_pend_txn, o_err_valid, o_m_w_valid); end
        #1;
        rst_n = 0;
        #1;
        nChecks++; if ({o_m_ar_valid, o_m_aw_valid, o_m_w_valid, o_rdat_valid, o_m_r_ready} !== 5'b0) begin nFails++; $display("[TB] FAIL async_valids: got %b%b%b%b%b want 00000", o_m_ar_valid, o_m_aw_valid, o_m_w_valid, o_rdat_valid, o_m_r_ready); end
        nChecks++; if ({o_pend_txn, o_err_valid, o_err_addr} !== 33'h0) begin nFails++; $display("[TB] FAIL async_counters: got %b %b %h want 0 0 0", o_pend_txn, o_err_valid, o_err_addr); end
        idleInputs;
        tick;
        rst_n = 1;
        tick;
    endtask

    // Run every scenario in order, then report
    initial begin
        test_reset;
        test_read_strobes;
        test_rd_outstanding;
        test_write_aw_stall;
        test_abort;
        test_errors;
        test_async_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule

// File: doc/dma_axi_if_param.md
Name: dma_axi_if_param

Overview:
Parametrised AXI4 master interface between the DMA rd/wr streamers, the DMA data FIFO and the system bus. It is the successor to the fixed-width interface block. It generalises address, data and ID width and the outstanding-transaction depth, and adds per-beat first/last byte strobes, AR/AW output registers, drain-on-deactivate and first-error capture.

Parameters:
ADDR_W, 32, address width
DATA_W, 64, data width (power of 2, >=32); STRB_W=DATA_W/8
ID_W, 4, AXI ID width
MAX_RD_OUT, 4, max outstanding read bursts (power of 2)
MAX_WR_OUT, 4, max outstanding write bursts (power of 2)
DMA_ID, 0, value driven on arid/awid

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
rd_req_*  mixed  -  rd streamer: valid i1, ready o1, addr i ADDR_W, len i8, size i3, first_strb i STRB_W, last_strb i STRB_W
wr_req_*  mixed  -  wr streamer: same fields as rd_req_*
rdat_*  mixed  -  to data FIFO: valid o1, data o DATA_W, ready i1 (=~full)
wdat_*  mixed  -  from data FIFO: valid i1 (=~empty), data i DATA_W, ready o1 (pop)
m_ar_*  mixed  -  AXI AR: valid o, ready i, addr, len, size, burst(=INCR), id, prot(=3'b010)
m_r_*  mixed  -  AXI R: valid i, ready o, data, resp, last
m_aw_*  mixed  -  AXI AW: same fields as m_ar_*
m_w_*  mixed  -  AXI W: valid o, ready i, data, strb, last
m_b_*  mixed  -  AXI B: valid i, ready o, resp
dma_active  in  1  enable acceptance of new requests
dma_abort  in  1  drain: discard read data, send zero-strobe writes
clear_err  in  1  clear error record and unlock
pend_txn  out  1  any burst outstanding or AR/AW pending
err_valid  out  1  error captured
err_src  out  1  0=read, 1=write
err_addr  out  ADDR_W  start address of the failing burst

Behaviour:
- Reset: all valid/ready outputs 0; counters, context FIFOs, error record and beat counters 0. Asynchronous reset mid-burst aborts immediately with no bus-level recovery.
- AR: a request is accepted when dma_active && rd_req_valid && !m_ar_valid && rd_out<MAX_RD_OUT.
  - rd_req_ready pulses for 1 cycle on acceptance.
  - Fields are registered; m_ar_valid rises the next cycle and stays stable until m_ar_ready.
- rd_out counter, width $clog2(MAX+1): +1 on acceptance, -1 on R handshake with last; both in the same cycle leaves it unchanged.
- Read context FIFO (depth MAX_RD_OUT) holds {addr, len, first_strb, last_strb}. Push on acceptance, pop on R last handshake.
- Read beat masking by beat counter b:
  - b==0: first_strb.
  - b==len: last_strb.
  - len==0: first_strb & last_strb.
  - Otherwise all ones.
  - Masked bytes are forced to 0. b resets on last.
- R channel: m_r_ready = rdat_ready || dma_abort; rdat_valid = m_r_valid && !dma_abort.
- AW: same acceptance rule using wr_out<MAX_WR_OUT. Acceptance also pushes {len, first_strb, last_strb} into the W context FIFO, so W may start before AW handshakes.
- wr_out: +1 on acceptance, -1 on B handshake.
- W channel:
  - m_w_valid = W ctx non-empty && (wdat_valid || dma_abort).
  - Strobe uses the same per-beat rule as reads; m_w_last = (b==len).
  - Under abort, data and strb are 0.
  - wdat_ready = m_w_valid && m_w_ready && !dma_abort.
  - Pop the W context on the last handshake.
- m_b_ready is always 1.
- dma_active low blocks new acceptances only; in-flight bursts and counters drain normally.
- pend_txn = |rd_out || |wr_out || m_ar_valid || m_aw_valid.
- Errors: resp[1]==1 (SLVERR/DECERR) on any R beat or on B sets the error record, with err_addr taken from the head context, when unlocked. The record then locks.
  - R and B errors in the same cycle: read wins.
  - clear_err together with a new error: clear wins.

Optional Feature:
DMA_AXI_IF_PERF_EN:
- When defined, adds outputs perf_rd_beats and perf_wr_beats (32 bits each). They count R and W handshakes, saturate at all-ones and are cleared by clear_err.
- When undefined, these ports and counters are absent.

Test Plan:
- Read len=3, addr 0x1000, first_strb=0xF0, last_strb=0x0F, DATA_W=64, rdata=all 0xFF -> rdat beats 0xFFFFFFFF00000000, 0xFF..FF, 0xFF..FF, 0x00000000FFFFFFFF; rd_out returns to 0.
- 5 read requests with m_ar_ready=1 and R stalled, MAX_RD_OUT=4 -> 4 AR handshakes, 5th rd_req_ready stays 0 until the first R last.
- Write len=1 with awready held low 10 cycles -> m_w beats complete, m_aw_valid and addr stable for all 10 cycles, single B handshake then wr_out=0.
- dma_abort during a 4-beat write with wdat empty -> 4 W beats with strb=0 and wlast on beat 3; wdat_ready never asserted.
- R resp=SLVERR on burst at 0x2000, then B resp=DECERR -> err_valid=1, src=0, addr=0x2000 locked; clear_err -> all zero.
- rst_n low mid-burst -> all valids low and counters 0 asynchronously, without waiting for a clk edge.
